// File: rtl/apb_ram_arbiter.sv
// apb_ram_arbiter: round-robin two-requester APB master for the APB RAM slave.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles without PREADY.
module apb_ram_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_done,
    output logic              req0_err,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_done,
    output logic              req1_err,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              PSEL1,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    state_t state, state_nxt;
    logic   gnt, pick, tmo_hit, finish;

    if (TIMEOUT < 2 || TIMEOUT > 15) begin : g_bad_timeout
        $error("apb_ram_arbiter: TIMEOUT must be within 2..15");
    end

    // gnt doubles as the last-grant pointer: on a tie the other port wins
    assign pick   = req1_valid && (!req0_valid || !gnt);
    assign finish = (state == ACCESS) && (PREADY || tmo_hit);

`ifdef APB_ARB_TIMEOUT_EN
    logic [3:0] cnt;
    logic       timed_out;
    assign tmo_hit = (state == ACCESS) && !PREADY && (cnt == 4'(TIMEOUT - 1));
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt       <= '0;
            timed_out <= 1'b0;
        end else begin
            cnt       <= (state == SETUP) ? 4'd0 : (state == ACCESS && !PREADY) ? cnt + 4'd1 : cnt;
            timed_out <= finish ? tmo_hit : timed_out;
        end
    end
    assign req0_err = req0_done && timed_out;
    assign req1_err = req1_done && timed_out;
`else
    assign tmo_hit  = 1'b0;
    assign req0_err = 1'b0;
    assign req1_err = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE)   ? ((req0_valid || req1_valid) ? SETUP : IDLE) :
                    (state == SETUP)  ? ACCESS :
                    (state == ACCESS) ? (finish ? DONE : ACCESS) : IDLE;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            gnt        <= 1'b1;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            req0_rdata <= '0;
            req1_rdata <= '0;
        end else begin
            if (state == IDLE && (req0_valid || req1_valid)) begin
                gnt    <= pick;
                PWRITE <= pick ? req1_write : req0_write;
                PADDR  <= pick ? req1_addr  : req0_addr;
                PWDATA <= pick ? req1_wdata : req0_wdata;
            end
            // a timeout clears the port's read data even for writes
            if (finish && !gnt && (tmo_hit || !PWRITE)) req0_rdata <= tmo_hit ? '0 : PRDATA;
            if (finish &&  gnt && (tmo_hit || !PWRITE)) req1_rdata <= tmo_hit ? '0 : PRDATA;
        end
    end

    assign PSEL1     = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);
    assign req0_done = (state == DONE) && !gnt;
    assign req1_done = (state == DONE) &&  gnt;
endmodule

// File: doc/apb_ram_arbiter.md
# apb_ram_arbiter

Two-port APB master that shares the single-cycle-registered APB RAM slave (PSEL1 select, 8-bit address/data) between two on-chip requesters. Each requester issues one transfer at a time over a valid/done handshake. The arbiter grants round-robin, runs a standard SETUP/ACCESS APB transfer, waits on PREADY and returns read data. It sits between the core-side requesters (CPU load/store port, DMA) and the APB RAM slave.

## Interface
- ADDR_W, 8, address width (matches slave PADDR)
- DATA_W, 8, data width (matches slave PWDATA/PRDATA)
- TIMEOUT, 15, max ACCESS cycles waiting for PREADY (used only with APB_ARB_TIMEOUT_EN); 4-bit counter, legal 2..15
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset, asynchronous, active-high
- reqN_valid  in  1  (N=0,1) transfer request; held with fields stable until reqN_done
- reqN_write  in  1  1=write, 0=read
- reqN_addr  in  ADDR_W  target address
- reqN_wdata  in  DATA_W  write data
- reqN_done  out  1  one-cycle completion pulse
- reqN_err  out  1  one-cycle timeout pulse, coincident with reqN_done
- reqN_rdata  out  DATA_W  read data, valid while reqN_done=1; holds until next completion on that port
- PSEL1, PENABLE, PWRITE  out  1  APB master controls
- PADDR  out  ADDR_W; PWDATA  out  DATA_W
- PRDATA  in  DATA_W; PREADY  in  1  slave response

## Operation
- States: IDLE, SETUP, ACCESS, DONE; registered; reset to IDLE.
- IDLE: if any reqN_valid, pick winner, latch its write/addr/wdata into PWRITE/PADDR/PWDATA registers, record grant, go SETUP. Else stay.
- Arbitration: only one valid -> that one. Both valid -> the port NOT granted last. Last-grant pointer resets to 1, so req0 wins the first tie.
- SETUP: PSEL1=1, PENABLE=0, one cycle; always -> ACCESS.
- ACCESS: PSEL1=1, PENABLE=1. PREADY=1 -> capture PRDATA (reads only) into granted reqN_rdata, go DONE. PREADY=0 -> stay.
- DONE: PSEL1=PENABLE=0; granted reqN_done=1 for this cycle only; -> IDLE. No arbitration in DONE, so the completed requester has one cycle to drop or change valid.
- Writes leave reqN_rdata unchanged.
- PADDR/PWDATA/PWRITE change only on IDLE->SETUP; held otherwise. Reset value 0.
- Non-granted requester stays pending and is not disturbed.
- Reset at any time: state IDLE; PSEL1, PENABLE, PWRITE, PADDR, PWDATA, reqN_done, reqN_err, reqN_rdata all 0; pointer=1. An in-flight transfer is dropped with no done pulse, and the requester must reissue. Slave-side effect of a dropped write is undefined.

## Timing
- Request at cycle 0 in IDLE -> SETUP cycle 1 -> ACCESS cycle 2 -> (slave registers PREADY) ACCESS cycle 3 with PREADY=1 -> DONE cycle 4 (done pulse, rdata valid) -> IDLE cycle 5.
- Against this slave: 5 cycles per transfer. Back-to-back, the second grant enters SETUP at cycle 6.
- Each extra PREADY=0 cycle adds one cycle in ACCESS.
- Outputs are registered or decoded from registered state only; no combinational path from reqN_* or PREADY to APB outputs.

## Configuration
- APB_ARB_TIMEOUT_EN defined: a counter clears on SETUP->ACCESS and increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT, go to DONE with reqN_done=1, reqN_err=1 and reqN_rdata=0 (also for writes).
- APB_ARB_TIMEOUT_EN undefined: ACCESS waits indefinitely, reqN_err is tied 0, and no counter is built.

## Test plan
- Reset: assert PRESET mid-ACCESS -> PSEL1=PENABLE=0, all done/err/rdata 0 immediately; after release, state IDLE.
- Write 0xA5 to 0x3C via req0, then read 0x3C via req1 -> req0_done at cycle 4; req1_done with req1_rdata=0xA5; PADDR stays 0x3C from SETUP through ACCESS.
- Both valid in the same cycle, repeated 4 transfers -> grant order 0,1,0,1; each done 5 cycles apart, no lost requests.
- Only req1 valid continuously, new address each done -> req1 granted every transfer, and req0 stays untouched.
- PREADY held 0 by a stub slave for 6 extra cycles -> done arrives 6 cycles later and err=0; PADDR/PWDATA stay stable throughout.
- With APB_ARB_TIMEOUT_EN and TIMEOUT=4, PREADY stuck 0 -> done+err pulse after 4 ACCESS cycles, rdata=0x00, return to IDLE.
